pingpong_bram_buf: RTL and testbench



---
 rtl/pingpong_buf_pkg.sv | 26 ++
 rtl/sdp_ram_core.sv | 57 +++++
 rtl/pingpong_bram_buf.sv | 166 ++++++++++++++++
 tb/tb_pingpong_bram_buf.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_buf_pkg.sv
// Shared constants and elaboration-time checks for the ping-pong BRAM buffer.
package pingpong_buf_pkg;

   // Read pipeline depth: RAM address reg, RAM output reg, output reg.
   localparam int RD_LATENCY = 3;

   // Legal write-to-read width ratios.
   localparam int RATIO_1 = 1;
   localparam int RATIO_2 = 2;
   localparam int RATIO_4 = 4;
   localparam int RATIO_8 = 8;

   // True when the read width is a legal multiple of the write width.
   function automatic bit ratio_ok(input int wa, input int wb);
      int r;
      if (wa <= 0 || (wb % wa) != 0) return 1'b0;
      r = wb / wa;
      return (r == RATIO_1) || (r == RATIO_2) || (r == RATIO_4) || (r == RATIO_8);
   endfunction

   // True for a positive power of two.
   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Single-clock mixed-width simple-dual-port RAM. Read path has a registered
// address and a registered output (two cycles). Contents are never cleared.
module sdp_ram_core #(
   parameter int    WA             = 32,
   parameter int    WB             = 32,
   parameter int    DEPTH_A        = 512,
   parameter string RAM_BLOCK_TYPE = "AUTO",
   localparam int   R              = WB / WA,
   localparam int   DEPTH_B        = DEPTH_A / R,
   localparam int   AWA            = $clog2(DEPTH_A),
   localparam int   AWB            = $clog2(DEPTH_B)
) (
   input  logic           clock,
   input  logic           aclr_n,
   input  logic           wr_en,
   input  logic [AWA-1:0] wr_addr,
   input  logic [WA-1:0]  wr_data,
   input  logic           rd_en,
   input  logic [AWB-1:0] rd_addr,
   output logic [WB-1:0]  q
);

   if (RAM_BLOCK_TYPE == "") begin : g_bad_block_type
      $error("sdp_ram_core: RAM_BLOCK_TYPE must not be empty");
   end

   logic [WA-1:0]  mem [DEPTH_A];
   logic [AWB-1:0] rd_addr_q;
   logic [WB-1:0]  q_q;
   logic [WB-1:0]  rd_word;

   // Write port: one A-word per cycle.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Gather R consecutive A-words, lowest A-address in the LSBs.
   always_comb begin
      rd_word = '0;
      for (int j = 0; j < R; j++)
         rd_word[j*WA +: WA] = mem[AWA'(int'(rd_addr_q) * R + j)];
   end

   // Registered read address and registered read data.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         rd_addr_q <= '0;
         q_q       <= '0;
      end else begin
         if (rd_en) rd_addr_q <= rd_addr;
         q_q <= rd_word;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pingpong_bram_buf.sv
// Two-bank ping-pong buffer: producer fills one bank with A-words while the
// consumer randomly reads the other (closed) bank as B-words.
// Optional build macro PINGPONG_BUF_STATS_EN adds ovf_cnt/frame_cnt outputs.
module pingpong_bram_buf
   import pingpong_buf_pkg::*;
#(
   parameter int    DATA_WIDTH_A   = 32,
   parameter int    DATA_WIDTH_B   = 32,
   parameter int    NUMWORDS_A     = 256,
   parameter string RAM_BLOCK_TYPE = "AUTO",
   localparam int   R              = DATA_WIDTH_B / DATA_WIDTH_A,
   localparam int   NUMWORDS_B     = NUMWORDS_A / R,
   localparam int   AW_A           = $clog2(NUMWORDS_A),
   localparam int   AW_B           = $clog2(NUMWORDS_B)
) (
   input  logic                    clock,
   input  logic                    aclr_n,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH_A-1:0] wr_data,
   input  logic                    wr_last,
   output logic                    wr_ready,
   output logic                    ovf,
   output logic                    rd_bank_valid,
   output logic [AW_A:0]           rd_bank_len,
   input  logic                    rd_en,
   input  logic [AW_B-1:0]         rd_addr,
   input  logic                    rd_done,
   output logic [DATA_WIDTH_B-1:0] q,
   output logic                    q_valid
`ifdef PINGPONG_BUF_STATS_EN
  ,output logic [15:0]             ovf_cnt,
   output logic [15:0]             frame_cnt
`endif
);

   if (!ratio_ok(DATA_WIDTH_A, DATA_WIDTH_B)) begin : g_bad_ratio
      $error("pingpong_bram_buf: DATA_WIDTH_B/DATA_WIDTH_A must be 1, 2, 4 or 8");
   end
   if (!is_pow2(NUMWORDS_A)) begin : g_bad_depth
      $error("pingpong_bram_buf: NUMWORDS_A must be a power of two");
   end

   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [1:0]            bank_full_q, bank_full_d;
   logic [AW_A-1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0][AW_A:0]    len_q, len_d;
   logic                  ovf_q, ovf_d;
   logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
   logic [DATA_WIDTH_B-1:0] q_q, q_d;
   logic [DATA_WIDTH_B-1:0] ram_q;

   logic wr_acc, wr_close, rd_iss, rd_rel;

   assign wr_ready      = ~bank_full_q[wr_bank_q];
   assign rd_bank_valid = bank_full_q[rd_bank_q];
   assign rd_bank_len   = len_q[rd_bank_q];

   assign wr_acc   = wr_en & wr_ready;
   // Last word of a bank closes it even without wr_last (pointer wraps).
   assign wr_close = wr_acc & (wr_last | (&wr_ptr_q));
   assign rd_iss   = rd_en & rd_bank_valid;
   assign rd_rel   = rd_done & rd_bank_valid;

   // Bank ownership, write pointer and frame length bookkeeping. Close and
   // release always target different banks, so both can apply together.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      bank_full_d = bank_full_q;
      wr_ptr_d    = wr_ptr_q;
      len_d       = len_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (wr_close) begin
            bank_full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]       = {1'b0, wr_ptr_q} + 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_ptr_d               = '0;
         end
      end
      if (rd_rel) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = ~rd_bank_q;
      end
   end

   // Overflow flag, read-valid shift register and output data register.
   always_comb begin
      ovf_d      = wr_en & ~wr_ready;
      vld_pipe_d = {vld_pipe_q[RD_LATENCY-2:0], rd_iss};
      q_d        = q_q;
      if (vld_pipe_q[RD_LATENCY-2]) q_d = ram_q;
   end

   // State registers.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         bank_full_q <= '0;
         wr_ptr_q    <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         vld_pipe_q  <= '0;
         q_q         <= '0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         bank_full_q <= bank_full_d;
         wr_ptr_q    <= wr_ptr_d;
         len_q       <= len_d;
         ovf_q       <= ovf_d;
         vld_pipe_q  <= vld_pipe_d;
         q_q         <= q_d;
      end
   end

   assign ovf     = ovf_q;
   assign q       = q_q;
   assign q_valid = vld_pipe_q[RD_LATENCY-1];

   sdp_ram_core #(
      .WA             (DATA_WIDTH_A),
      .WB             (DATA_WIDTH_B),
      .DEPTH_A        (2 * NUMWORDS_A),
      .RAM_BLOCK_TYPE (RAM_BLOCK_TYPE)
   ) u_ram (
      .clock   (clock),
      .aclr_n  (aclr_n),
      .wr_en   (wr_acc),
      .wr_addr ({wr_bank_q, wr_ptr_q}),
      .wr_data (wr_data),
      .rd_en   (rd_iss),
      .rd_addr ({rd_bank_q, rd_addr}),
      .q       (ram_q)
   );

`ifdef PINGPONG_BUF_STATS_EN
   logic [15:0] ovf_cnt_q, ovf_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Saturating drop counter and wrapping bank-close counter.
   always_comb begin
      ovf_cnt_d   = ovf_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (ovf_d && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 1'b1;
      if (wr_close) frame_cnt_d = frame_cnt_q + 1'b1;
   end

   // Statistics registers.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         ovf_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         ovf_cnt_q   <= ovf_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign ovf_cnt   = ovf_cnt_q;
   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_bram_buf.sv
// Directed bench for pingpong_bram_buf with A=32, B=64, N=8 (R=2).
module tb_pingpong_bram_buf;

   localparam int WA = 32;
   localparam int WB = 64;
   localparam int N  = 8;

   logic          clock = 1'b0;
   logic          aclr_n;
   logic          wr_en, wr_last, wr_ready, ovf, rd_bank_valid;
   logic [31:0]   wr_data;
   logic [3:0]    rd_bank_len;
   logic          rd_en, rd_done, q_valid;
   logic [1:0]    rd_addr;
   logic [63:0]   q;
`ifdef PINGPONG_BUF_STATS_EN
   logic [15:0]   ovf_cnt, frame_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pingpong_bram_buf #(
      .DATA_WIDTH_A   (WA),
      .DATA_WIDTH_B   (WB),
      .NUMWORDS_A     (N),
      .RAM_BLOCK_TYPE ("AUTO")
   ) dut (
      .clock         (clock),
      .aclr_n        (aclr_n),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .wr_last       (wr_last),
      .wr_ready      (wr_ready),
      .ovf           (ovf),
      .rd_bank_valid (rd_bank_valid),
      .rd_bank_len   (rd_bank_len),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_done       (rd_done),
      .q             (q),
      .q_valid       (q_valid)
`ifdef PINGPONG_BUF_STATS_EN
     ,.ovf_cnt       (ovf_cnt),
      .frame_cnt     (frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] d, input logic last);
      wr_en = 1'b1; wr_data = d; wr_last = last;
      cyc();
      wr_en = 1'b0; wr_last = 1'b0;
   endtask

   // Single read; q_valid must be low after two edges and high after three.
   task automatic rd_chk(input string tag, input logic [1:0] a,
                         input logic [63:0] exp, input logic [63:0] mask);
      rd_en = 1'b1; rd_addr = a;
      cyc();
      rd_en = 1'b0;
      cyc();
      chk({tag, "_early"}, {63'd0, q_valid}, 64'd0);
      cyc();
      chk({tag, "_qv"}, {63'd0, q_valid}, 64'd1);
      chk(tag, q & mask, exp & mask);
   endtask

   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] LO  = 64'h0000_0000_FFFF_FFFF;

   initial begin
      aclr_n = 1'b0; wr_en = 0; wr_data = 0; wr_last = 0;
      rd_en = 0; rd_addr = 0; rd_done = 0;
      cyc(); cyc();
      chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      chk("rst_rd_valid", {63'd0, rd_bank_valid}, 64'd0);
      chk("rst_len", {60'd0, rd_bank_len}, 64'd0);
      chk("rst_q", q, 64'd0);
      chk("rst_qv", {63'd0, q_valid}, 64'd0);
      aclr_n = 1'b1;
      cyc();

      // Full bank 0 via auto-close, then a back-to-back burst read.
      for (int i = 0; i < 8; i++) wr(32'(i), 1'b0);
      chk("t1_valid", {63'd0, rd_bank_valid}, 64'd1);
      chk("t1_len", {60'd0, rd_bank_len}, 64'd8);
      chk("t1_wr_ready", {63'd0, wr_ready}, 64'd1);
      for (int k = 0; k < 4; k++) begin
         rd_en = 1'b1; rd_addr = 2'(k);
         cyc();
         if (k >= 2) chk($sformatf("t1_burst%0d", k - 2), q, {32'(2*k-3), 32'(2*k-4)});
      end
      rd_en = 1'b0;
      cyc();
      chk("t1_burst2", q, {32'd5, 32'd4});
      cyc();
      chk("t1_burst3", q, {32'd7, 32'd6});
      chk("t1_burst_qv", {63'd0, q_valid}, 64'd1);
      rd_done = 1'b1;
      cyc();
      rd_done = 1'b0;
      chk("t1_released", {63'd0, rd_bank_valid}, 64'd0);
      chk("t1_len_b1", {60'd0, rd_bank_len}, 64'd0);

      // Read with no bank available is ignored.
      rd_en = 1'b1; rd_addr = 2'd0;
      cyc();
      rd_en = 1'b0;
      cyc(); cyc();
      chk("ign_rd_qv", {63'd0, q_valid}, 64'd0);

      // Short frame into bank 1 closed by wr_last.
      wr(32'hA0, 1'b0); wr(32'hA1, 1'b0); wr(32'hA2, 1'b1);
      chk("t2_valid", {63'd0, rd_bank_valid}, 64'd1);
      chk("t2_len", {60'd0, rd_bank_len}, 64'd3);
      rd_chk("t2_rd1", 2'd1, {32'd0, 32'hA2}, LO);
      rd_chk("t2_rd0", 2'd0, {32'hA1, 32'hA0}, ALL);
      rd_done = 1'b1;
      cyc();
      rd_done = 1'b0;

      // Both banks full, then a dropped write.
      for (int i = 0; i < 8; i++) wr(32'h10 + 32'(i), 1'b0);
      wr(32'h20, 1'b0); wr(32'h21, 1'b1);
      chk("t3_wr_ready0", {63'd0, wr_ready}, 64'd0);
      chk("t3_ovf_pre", {63'd0, ovf}, 64'd0);
      wr(32'hDEAD, 1'b0);
      chk("t3_ovf", {63'd0, ovf}, 64'd1);
      cyc();
      chk("t3_ovf_clr", {63'd0, ovf}, 64'd0);
      chk("t3_wr_ready_still0", {63'd0, wr_ready}, 64'd0);
      chk("t3_len", {60'd0, rd_bank_len}, 64'd8);
      rd_chk("t3_rd3", 2'd3, {32'h17, 32'h16}, ALL);
`ifdef PINGPONG_BUF_STATS_EN
      chk("t3_ovf_cnt", {48'd0, ovf_cnt}, 64'd1);
      chk("t3_frame_cnt", {48'd0, frame_cnt}, 64'd4);
`endif

      // Read and release together; writer immediately overwrites address 0.
      rd_en = 1'b1; rd_addr = 2'd0; rd_done = 1'b1;
      cyc();
      rd_en = 1'b0; rd_done = 1'b0;
      chk("t4_wr_ready", {63'd0, wr_ready}, 64'd1);
      wr_en = 1'b1; wr_data = 32'hBB; wr_last = 1'b0;
      cyc();
      wr_data = 32'hBC;
      cyc();
      wr_en = 1'b0;
      chk("t4_qv", {63'd0, q_valid}, 64'd1);
      chk("t4_old_data", q, {32'h11, 32'h10});
      chk("t4_len_b1", {60'd0, rd_bank_len}, 64'd2);

      // Close bank 0 while releasing bank 1 in the same cycle.
      wr_en = 1'b1; wr_data = 32'hBD; wr_last = 1'b1; rd_done = 1'b1;
      cyc();
      wr_en = 1'b0; wr_last = 1'b0; rd_done = 1'b0;
      chk("t5_valid", {63'd0, rd_bank_valid}, 64'd1);
      chk("t5_len", {60'd0, rd_bank_len}, 64'd3);
      chk("t5_wr_ready", {63'd0, wr_ready}, 64'd1);
      rd_chk("t5_rd0", 2'd0, {32'hBC, 32'hBB}, ALL);
      rd_chk("t5_rd1", 2'd1, {32'd0, 32'hBD}, LO);

      // Asynchronous reset in the middle of a frame.
      wr(32'h55, 1'b0); wr(32'h56, 1'b0);
      aclr_n = 1'b0;
      #1;
      chk("t6_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("t6_ovf", {63'd0, ovf}, 64'd0);
      chk("t6_valid", {63'd0, rd_bank_valid}, 64'd0);
      chk("t6_len", {60'd0, rd_bank_len}, 64'd0);
      chk("t6_q", q, 64'd0);
      chk("t6_qv", {63'd0, q_valid}, 64'd0);
`ifdef PINGPONG_BUF_STATS_EN
      chk("t6_ovf_cnt", {48'd0, ovf_cnt}, 64'd0);
      chk("t6_frame_cnt", {48'd0, frame_cnt}, 64'd0);
`endif
      cyc();
      aclr_n = 1'b1;
      cyc();
      wr(32'h70, 1'b0); wr(32'h71, 1'b0); wr(32'h72, 1'b1);
      chk("t6_new_valid", {63'd0, rd_bank_valid}, 64'd1);
      chk("t6_new_len", {60'd0, rd_bank_len}, 64'd3);
      rd_chk("t6_rd0", 2'd0, {32'h71, 32'h70}, ALL);
      rd_chk("t6_rd1", 2'd1, {32'd0, 32'h72}, LO);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
